// File: rtl/mul_div_if.sv
// Request/response bundle for mul_div_unit: master drives Start/Op/operands,
// slave returns Busy/Done/Result.
interface mul_div_if #(parameter int D_WIDTH = 32);
  logic               Start;
  logic [1:0]         Op;
  logic [D_WIDTH-1:0] SrcA;
  logic [D_WIDTH-1:0] SrcB;
  logic               Busy;
  logic               Done;
  logic [D_WIDTH-1:0] Result;

  modport master (output Start, Op, SrcA, SrcB, input Busy, Done, Result);
  modport slave  (input Start, Op, SrcA, SrcB, output Busy, Done, Result);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M divide/remainder unit (radix-2 restoring, one bit per cycle).
// MUL_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass CALC.
module mul_div_unit #(
  parameter int D_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_div_if.slave   bus
);
  localparam int CW = (D_WIDTH > 2) ? $clog2(D_WIDTH) : 1;
  localparam logic [CW-1:0]      LAST    = CW'(D_WIDTH - 1);
  localparam logic [D_WIDTH-1:0] MOST_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, ADJUST} state_t;

  state_t             r_state;
  logic               r_busy, r_done;
  logic [D_WIDTH-1:0] r_result;
  logic [CW-1:0]      r_cnt;
  logic [D_WIDTH-1:0] r_quo, r_rem, r_b, r_a_raw;
  logic               r_is_rem, r_neg_q, r_neg_r, r_div0, r_ovf;

  // Op[0] = unsigned, Op[1] = remainder
  logic               w_signed, w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [D_WIDTH-1:0] w_a_mag, w_b_mag;
  state_t             w_accept_state;

  always_comb begin
    w_signed = ~bus.Op[0];
    w_a_neg  = w_signed & bus.SrcA[D_WIDTH-1];
    w_b_neg  = w_signed & bus.SrcB[D_WIDTH-1];
    w_a_mag  = w_a_neg ? (~bus.SrcA + 1'b1) : bus.SrcA;
    w_b_mag  = w_b_neg ? (~bus.SrcB + 1'b1) : bus.SrcB;
    w_div0   = (bus.SrcB == '0);
    w_ovf    = w_signed && (bus.SrcA == MOST_NEG) && (bus.SrcB == '1);
`ifdef MUL_DIV_EARLY_OUT_EN
    w_accept_state = (w_div0 || w_ovf) ? ADJUST : CALC;
`else
    w_accept_state = CALC;
`endif
  end

  // One restoring step: shift next dividend bit into the partial remainder,
  // subtract the divisor when it fits.
  logic [D_WIDTH:0]   w_shift, w_diff;
  logic               w_fits;
  logic [D_WIDTH-1:0] w_rem_nxt, w_quo_nxt;

  always_comb begin
    w_shift   = {r_rem, r_quo[D_WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_b};
    w_fits    = ~w_diff[D_WIDTH];
    w_rem_nxt = w_fits ? w_diff[D_WIDTH-1:0] : w_shift[D_WIDTH-1:0];
    w_quo_nxt = {r_quo[D_WIDTH-2:0], w_fits};
  end

  logic [D_WIDTH-1:0] w_q_fix, w_r_fix, w_result;

  always_comb begin
    w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
    // Special cases are resolved explicitly so early-out needs no iteration data
    if (r_div0)     w_result = r_is_rem ? r_a_raw : '1;
    else if (r_ovf) w_result = r_is_rem ? '0 : MOST_NEG;
    else            w_result = r_is_rem ? w_r_fix : w_q_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_b      <= '0;
      r_a_raw  <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.Start) begin
          r_quo    <= w_a_mag;
          r_rem    <= '0;
          r_b      <= w_b_mag;
          r_a_raw  <= bus.SrcA;
          r_is_rem <= bus.Op[1];
          r_neg_q  <= w_a_neg ^ w_b_neg;
          r_neg_r  <= w_a_neg;
          r_div0   <= w_div0;
          r_ovf    <= w_ovf;
          r_cnt    <= '0;
          r_busy   <= 1'b1;
          r_state  <= w_accept_state;
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= ADJUST;
        end
        ADJUST: begin
          r_result <= w_result;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;
  assign bus.Result = r_result;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized + directed bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  localparam int W = 32;
  localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;
`ifdef MUL_DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = W + 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_if #(.D_WIDTH(W)) bus ();
  mul_div_unit #(.D_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: RISC-V division semantics from plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) return op[1] ? a : {W{1'b1}};
    case (op)
      DIV:     return W'(sa / sb);
      DIVU:    return a / b;
      REM:     return W'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return EARLY_LAT;
    return W + 1;
  endfunction

  // Cycle-level model: busy for N edges after acceptance, then a one-cycle Done.
  logic          m_busy, m_done;
  logic [W-1:0]  m_res, m_pend;
  int            m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_pend <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_pend;
        end
      end else if (bus.Start) begin
        m_busy <= 1'b1;
        m_left <= ref_lat(bus.Op, bus.SrcA, bus.SrcB);
        m_pend <= ref_res(bus.Op, bus.SrcA, bus.SrcB);
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy",   W'(bus.Busy), W'(m_busy));
    chk("cyc_done",   W'(bus.Done), W'(m_done));
    chk("cyc_result", bus.Result,   m_res);
  end

  // Called at posedge+#1 with the DUT idle; optionally re-pulses Start mid-CALC.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int exp_lat, input bit glitch, input string nm);
    int n; bit seen;
    bus.Op = op; bus.SrcA = a; bus.SrcB = b; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.SrcA = $urandom; bus.SrcB = $urandom; bus.Op = 2'($urandom);
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      if (glitch && n == 5) begin
        bus.Start = 1'b1; bus.Op = DIV; bus.SrcA = 32'd7; bus.SrcB = 32'd3;
      end
      if (glitch && n == 6) bus.Start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (bus.Done) seen = 1;
    end
    chk({nm, "_done_seen"}, W'(seen), W'(1));
    chk({nm, "_latency"},   W'(n),    W'(exp_lat));
    chk({nm, "_result"},    bus.Result, exp);
  endtask

  initial begin
    int seen_done;
    logic [1:0] op;
    logic [W-1:0] a, b;
    bus.Start = 1'b0; bus.Op = '0; bus.SrcA = '0; bus.SrcB = '0;

    // Pin the reference model with hand-computed values
    chk("model_divu", ref_res(DIVU, 32'd100, 32'd7), 32'd14);
    chk("model_rem",  ref_res(REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_ovf",  ref_res(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   W'(bus.Busy), '0);
    chk("rst_done",   W'(bus.Done), '0);
    chk("rst_result", bus.Result,   '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(DIVU, 32'd100, 32'd7, 32'd14, 33, 0, "divu_100_7");
    run_op(REMU, 32'd100, 32'd7, 32'd2, 33, 0, "remu_100_7");
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div_m7_2");
    run_op(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem_m7_2");
    run_op(DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, EARLY_LAT, 0, "div_5_0");
    run_op(REM, 32'd5, 32'd0, 32'd5, EARLY_LAT, 0, "rem_5_0");
    run_op(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, EARLY_LAT, 0, "divu_5_0");
    run_op(REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, EARLY_LAT, 0, "rem_m7_0");
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY_LAT, 0, "div_ovf");
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EARLY_LAT, 0, "rem_ovf");
    run_op(DIVU, 32'd1000, 32'd10, 32'd100, 33, 1, "restart_ignored");

    // Start in the Done cycle is accepted
    bus.Start = 1'b1; bus.Op = DIVU; bus.SrcA = 32'd81; bus.SrcB = 32'd9;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    chk("done_cycle_accept_busy", W'(bus.Busy), W'(1));
    chk("result_held_during_calc", bus.Result, 32'd100);
    repeat (40) @(posedge clk);
    #1;
    chk("done_cycle_accept_result", bus.Result, 32'd9);

    // Reset mid-CALC, asynchronous to the clock
    bus.Start = 1'b1; bus.Op = DIVU; bus.SrcA = 32'd500; bus.SrcB = 32'd3;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy",   W'(bus.Busy), '0);
    chk("async_rst_done",   W'(bus.Done), '0);
    chk("async_rst_result", bus.Result,   '0);
    @(posedge clk); #3 rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.Done) seen_done++;
    end
    chk("no_done_after_rst", W'(seen_done), '0);
    run_op(DIVU, 32'd9, 32'd3, 32'd3, 33, 0, "divu_9_3_after_rst");

    // Start on the first edge after reset release
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    run_op(DIVU, 32'd9, 32'd3, 32'd3, 33, 0, "first_edge_after_rst");

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 5))
        0:       begin a = $urandom; b = '0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3:       begin a = -$urandom_range(0, 300); b = -$urandom_range(1, 20); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      run_op(op, a, b, ref_res(op, a, b), ref_lat(op, a, b), 0, "rand");
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
